id_stage: RTL and testbench

- Instruction-decode stage of the 16-bit pipelined CPU, and the reader/consumer end of the IF/ID pipeline register.
- Accepts the 32-bit IF/ID word: [31:16] = PC+2, [15:0] = instruction.
- Decodes the instruction, reads a 16x16 register file (written back from WB), detects load-use hazards and drives the ID/EX pipeline register.
- Issues stall controls back to IF (PC and IF/ID write enables).

---
 rtl/id_stage.sv | 175 +++++++++++++++++
 tb/tb_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the IF/ID word, reads the register file,
// detects load-use hazards and drives the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            ifid_in,
  input  logic                   ifid_valid,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [3:0]             wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   pc_write_en,
  output logic                   ifid_write_en,
  output logic                   idex_valid,
  output logic [DATA_W-1:0]      idex_pc_plus2,
  output logic [DATA_W-1:0]      idex_op1,
  output logic [DATA_W-1:0]      idex_op2,
  output logic [DATA_W-1:0]      idex_imm,
  output logic [3:0]             idex_dest,
  output logic [3:0]             idex_alu_op,
  output logic                   idex_mem_read,
  output logic                   idex_mem_write,
  output logic                   idex_reg_write,
  output logic                   idex_branch,
  output logic                   illegal,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [15:0]       instr;
  logic [15:0]       pc_plus2;
  logic [3:0]        opc, ra, rb, fn;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign instr    = ifid_in[15:0];
  assign pc_plus2 = ifid_in[31:16];
  assign opc      = instr[15:12];
  assign ra       = instr[11:8];
  assign rb       = instr[7:4];
  assign fn       = instr[3:0];

  // Write-through bypass lets WB and ID share a cycle without a hazard.
  assign rd_a = (wb_en && wb_addr == ra) ? wb_data : regs[ra];
  assign rd_b = (wb_en && wb_addr == rb) ? wb_data : regs[rb];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic              dec_legal, dec_halt, use_a, use_b;
  logic              dec_mr, dec_mw, dec_rw, dec_br;
  logic [DATA_W-1:0] dec_op1, dec_op2, dec_imm;
  logic [3:0]        dec_alu;

  always_comb begin
    dec_legal = 1'b1;
    dec_halt  = 1'b0;
    use_a     = 1'b0;
    use_b     = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_rw    = 1'b0;
    dec_br    = 1'b0;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_imm   = '0;
    dec_alu   = 4'b0000;
    unique case (opc)
      OP_RTYPE: begin
        use_a = 1'b1; use_b = 1'b1;
        dec_op1 = rd_a; dec_op2 = rd_b;
        dec_alu = fn; dec_rw = 1'b1;
      end
      OP_ADDI: begin
        use_a = 1'b1;
        dec_op1 = rd_a;
        dec_imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
        dec_rw = 1'b1;
      end
      OP_LW: begin
        use_b = 1'b1;
        dec_op1 = rd_b;
        dec_imm = {{(DATA_W-4){fn[3]}}, fn};
        dec_mr = 1'b1; dec_rw = 1'b1;
      end
      OP_SW: begin
        use_a = 1'b1; use_b = 1'b1;
        dec_op1 = rd_b; dec_op2 = rd_a;
        dec_imm = {{(DATA_W-4){fn[3]}}, fn};
        dec_mw = 1'b1;
      end
      OP_BEQ: begin
        use_a = 1'b1; use_b = 1'b1;
        dec_op1 = rd_a; dec_op2 = rd_b;
        dec_imm = {{(DATA_W-5){fn[3]}}, fn, 1'b0};
        dec_alu = 4'b0001; dec_br = 1'b1;
      end
      OP_HALT: dec_halt = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  logic hazard;

  assign hazard = ifid_valid && idex_valid && idex_mem_read &&
                  ((use_a && ra == idex_dest) || (use_b && rb == idex_dest));

  // Flush overrides a stall; reset releases it directly.
  assign pc_write_en   = !reset_n || flush || (!halted && !hazard);
  assign ifid_write_en = pc_write_en;

  // Every edge defaults to a bubble; only the normal-issue branch loads ID/EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_valid     <= 1'b0;
      idex_pc_plus2  <= '0;
      idex_op1       <= '0;
      idex_op2       <= '0;
      idex_imm       <= '0;
      idex_dest      <= '0;
      idex_alu_op    <= '0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_reg_write <= 1'b0;
      idex_branch    <= 1'b0;
      illegal        <= 1'b0;
      halted         <= 1'b0;
      stall_count    <= '0;
    end else begin
      idex_valid     <= 1'b0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_reg_write <= 1'b0;
      idex_branch    <= 1'b0;
      if (flush || halted || !ifid_valid) begin
      end else if (hazard) begin
        if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end else if (!dec_legal) begin
        illegal <= 1'b1;
      end else if (dec_halt) begin
        halted <= 1'b1;
      end else begin
        idex_valid     <= 1'b1;
        idex_pc_plus2  <= pc_plus2;
        idex_op1       <= dec_op1;
        idex_op2       <= dec_op2;
        idex_imm       <= dec_imm;
        idex_dest      <= ra;
        idex_alu_op    <= dec_alu;
        idex_mem_read  <= dec_mr;
        idex_mem_write <= dec_mw;
        idex_reg_write <= dec_rw;
        idex_branch    <= dec_br;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: table of decode cases plus hand-written
// hazard, illegal/HALT and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ifid_in;
  logic        ifid_valid, flush, wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        pc_write_en, ifid_write_en, idex_valid;
  logic [15:0] idex_pc_plus2, idex_op1, idex_op2, idex_imm;
  logic [3:0]  idex_dest, idex_alu_op;
  logic        idex_mem_read, idex_mem_write, idex_reg_write, idex_branch;
  logic        illegal, halted;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_stage dut (
    .clk(clk), .reset_n(reset_n), .ifid_in(ifid_in), .ifid_valid(ifid_valid),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_valid(idex_valid), .idex_pc_plus2(idex_pc_plus2),
    .idex_op1(idex_op1), .idex_op2(idex_op2), .idex_imm(idex_imm),
    .idex_dest(idex_dest), .idex_alu_op(idex_alu_op),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_reg_write(idex_reg_write), .idex_branch(idex_branch),
    .illegal(illegal), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [31:0] ifid;
    logic        valid;
    logic        flush;
    logic        exp_pcwe;
    logic        exp_valid;
    logic [15:0] exp_pc, exp_op1, exp_op2, exp_imm;
    logic [3:0]  exp_dest, exp_alu;
    logic        exp_mr, exp_mw, exp_rw, exp_br;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wb_en      = v.wb_en;
    wb_addr    = v.wb_addr;
    wb_data    = v.wb_data;
    ifid_in    = v.ifid;
    ifid_valid = v.valid;
    flush      = v.flush;
  endtask

  task automatic drive_instr(input logic [31:0] ifid);
    wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
    flush = 1'b0; ifid_valid = 1'b1; ifid_in = ifid;
  endtask

  task automatic check_stall_ctl(input string tag, input logic exp);
    check_val({tag, " pc_write_en"}, 32'(pc_write_en), 32'(exp));
    check_val({tag, " ifid_write_en"}, 32'(ifid_write_en), 32'(exp));
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check_val({tag, " valid"},     32'(idex_valid),     32'(v.exp_valid));
    check_val({tag, " pc_plus2"},  32'(idex_pc_plus2),  32'(v.exp_pc));
    check_val({tag, " op1"},       32'(idex_op1),       32'(v.exp_op1));
    check_val({tag, " op2"},       32'(idex_op2),       32'(v.exp_op2));
    check_val({tag, " imm"},       32'(idex_imm),       32'(v.exp_imm));
    check_val({tag, " dest"},      32'(idex_dest),      32'(v.exp_dest));
    check_val({tag, " alu_op"},    32'(idex_alu_op),    32'(v.exp_alu));
    check_val({tag, " mem_read"},  32'(idex_mem_read),  32'(v.exp_mr));
    check_val({tag, " mem_write"}, 32'(idex_mem_write), 32'(v.exp_mw));
    check_val({tag, " reg_write"}, 32'(idex_reg_write), 32'(v.exp_rw));
    check_val({tag, " branch"},    32'(idex_branch),    32'(v.exp_br));
    check_val({tag, " stall_cnt"}, 32'(stall_count),    32'(v.exp_stall));
  endtask

  task automatic check_reset_state(input string tag);
    vec_t z;
    z = '{1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0,
          16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    checkOutput(tag, z);
    check_val({tag, " illegal"}, 32'(illegal), 32'd0);
    check_val({tag, " halted"},  32'(halted),  32'd0);
    check_stall_ctl(tag, 1'b1);
  endtask

  initial begin
    //        wb  addr  data      ifid          vld flu pcwe val pc       op1      op2      imm      dst  alu  mr mw rw br stall
    vecs[0]  = '{1'b1, 4'h1, 16'h0005, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 4'h2, 16'h0003, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 32'h0002_0120, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0005, 16'h0003, 16'h0000, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 4'h3, 16'h0010, 32'h0004_13FE, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 16'h0010, 16'h0000, 16'hFFFE, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 4'h0, 16'h0000, 32'h0006_8410, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 16'h0005, 16'h0000, 16'h0000, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 4'h0, 16'h0000, 32'h0008_0540, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h0005, 16'h0000, 16'h0000, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 4'h4, 16'h0077, 32'h0008_0540, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0008, 16'h0000, 16'h0077, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[7]  = '{1'b0, 4'h0, 16'h0000, 32'h000A_B21F, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000A, 16'h0005, 16'h0003, 16'hFFFF, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 4'h0, 16'h0000, 32'h000C_4123, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 16'h0005, 16'h0003, 16'h0006, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b1, 4'h2, 16'hBEEF, 32'h000E_0025, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000E, 16'h0000, 16'hBEEF, 16'h0000, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 4'h0, 16'h0000, 32'h0010_8620, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 4'h6, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 4'h0, 16'h0000, 32'h0012_0760, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[12] = '{1'b0, 4'h0, 16'h0000, 32'h0012_0760, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};

    reset_n = 1'b0;
    drive_instr(32'h0);
    ifid_valid = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1 check_stall_ctl($sformatf("vec%0d", i), vecs[i].exp_pcwe);
      @(posedge clk);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Unknown opcode: bubble, sticky flag, pipeline keeps flowing.
    drive_instr(32'h0014_7000);
    @(posedge clk);
    #1;
    check_val("illegal flag", 32'(illegal), 32'd1);
    check_val("illegal bubble", 32'(idex_valid), 32'd0);
    check_val("illegal reg_write", 32'(idex_reg_write), 32'd0);
    check_stall_ctl("illegal", 1'b1);

    drive_instr(32'h0016_F000);
    @(posedge clk);
    #1;
    check_val("halt flag", 32'(halted), 32'd1);
    check_val("halt bubble", 32'(idex_valid), 32'd0);
    check_stall_ctl("halt", 1'b0);

    drive_instr(32'h0018_13FE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("halted hold%0d valid", i), 32'(idex_valid), 32'd0);
      check_stall_ctl($sformatf("halted hold%0d", i), 1'b0);
    end

    reset_n = 1'b0;
    #1 check_reset_state("halt reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Register file must come back cleared: R1/R2 read as zero.
    drive_instr(32'h0002_0120);
    @(posedge clk);
    #1;
    check_val("post-reset valid", 32'(idex_valid), 32'd1);
    check_val("post-reset op1", 32'(idex_op1), 32'd0);
    check_val("post-reset op2", 32'(idex_op2), 32'd0);
    check_val("post-reset dest", 32'(idex_dest), 32'd1);

    drive_instr(32'h0004_8410);
    @(posedge clk);
    #1 drive_instr(32'h0006_0540);
    #1 check_stall_ctl("mid-stall", 1'b0);
    reset_n = 1'b0;
    #1 check_stall_ctl("reset releases stall", 1'b1);
    check_val("reset stall_cnt", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
